// File: rtl/sharp_pkg.sv
// sharp_pkg: shared constants and helpers for the 3x3 window generator.
//   DEF_DATA_W   default pixel width
//   WIN_DIM/N    window edge length and element count
//   WIN_CENTRE   element index of the centre pixel (r-1, c-1)
//   WIN_NEWEST   element index of the just-accepted pixel (r, c)
//   win_off()    bit offset of window element k in the flattened window
package sharp_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned WIN_DIM    = 3;
    localparam int unsigned WIN_N      = WIN_DIM * WIN_DIM;
    localparam int unsigned WIN_CENTRE = 4;
    localparam int unsigned WIN_NEWEST = 8;

    // Element k occupies [data_w*k +: data_w] of the flattened window.
    function automatic int unsigned win_off(input int unsigned k, input int unsigned data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/sharp_line_buf.sv
// sharp_line_buf: single-port, DEPTH-deep, DATA_W-wide line memory.
//   i_clk      rising-edge clock
//   i_we       write enable (one write per accepted pixel)
//   i_addr     column address, shared by read and write
//   i_wdata    write data
//   o_rdata_c  combinational read of i_addr; always the pre-write contents,
//              so a read and write of the same column in one cycle returns
//              the old pixel that the window register captures on that edge
// Contents are deliberately not reset; the caller masks stale data.
module sharp_line_buf
    import sharp_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read port returns old data; the write lands on the same edge the reader samples.
    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/sharp_window_gen.sv
// sharp_window_gen: streaming 3x3 neighbourhood generator.
//   CLK        rising-edge clock
//   RST        asynchronous active-high reset
//   IN_DATA    pixel in raster order
//   IN_VALID   IN_DATA valid
//   IN_SOF     first pixel of a frame (qualified by IN_VALID)
//   IN_READY   block can accept a pixel this cycle (combinational)
//   OUT_WIN    3x3 window, element k = 3*i + j at [DATA_W*k +: DATA_W],
//              i = row (0 oldest), j = column (0 oldest)
//   OUT_VALID  OUT_WIN valid
//   OUT_EOF    OUT_WIN is the last window of the frame
//   OUT_READY  downstream consumes the window
module sharp_window_gen
    import sharp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_W-1:0]       IN_DATA,
    input  logic                    IN_VALID,
    input  logic                    IN_SOF,
    output logic                    IN_READY,
    output logic [WIN_N*DATA_W-1:0] OUT_WIN,
    output logic                    OUT_VALID,
    output logic                    OUT_EOF,
    input  logic                    OUT_READY
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned WIN_W = WIN_N * DATA_W;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_accept;
    logic [DATA_W-1:0] w_lb1_rd;
    logic [DATA_W-1:0] w_lb2_rd;
    logic [WIN_W-1:0]  r_win;
    logic [WIN_W-1:0]  w_win;
    logic              r_out_valid;
    logic              r_out_eof;

    // Handshake: a held window is the only thing that can block input.
    assign IN_READY = !r_out_valid || OUT_READY;
    assign w_accept = IN_VALID && IN_READY;

    // Effective position of the pixel being offered; SOF forces the origin.
    assign w_col      = IN_SOF ? '0 : r_col;
    assign w_row      = IN_SOF ? '0 : r_row;
    assign w_col_last = (w_col == COL_W'(IMG_W - 1));
    assign w_row_last = (w_row == ROW_W'(IMG_H - 1));

    // LB1 holds row r-1, LB2 row r-2; LB2 is refilled from LB1's old contents.
    sharp_line_buf #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .i_clk     (CLK),
        .i_we      (w_accept),
        .i_addr    (w_col),
        .i_wdata   (IN_DATA),
        .o_rdata_c (w_lb1_rd)
    );

    sharp_line_buf #(
        .DEPTH  (IMG_W),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb2 (
        .i_clk     (CLK),
        .i_we      (w_accept),
        .i_addr    (w_col),
        .i_wdata   (w_lb1_rd),
        .o_rdata_c (w_lb2_rd)
    );

    // Next window: each row shifts one column older, the new column enters at j=2.
    always_comb begin
        w_win = r_win;
        for (int unsigned i = 0; i < WIN_DIM; i++) begin
            for (int unsigned j = 0; j < WIN_DIM - 1; j++) begin
                w_win[win_off(WIN_DIM*i + j, DATA_W) +: DATA_W] =
                    r_win[win_off(WIN_DIM*i + j + 1, DATA_W) +: DATA_W];
            end
        end
        w_win[win_off(WIN_DIM - 1, DATA_W) +: DATA_W]     = w_lb2_rd;
        w_win[win_off(2*WIN_DIM - 1, DATA_W) +: DATA_W]   = w_lb1_rd;
        w_win[win_off(WIN_NEWEST, DATA_W) +: DATA_W]      = IN_DATA;
    end

    // Counters, window shift register and output flags.
    // The shift register only moves on accept, so it doubles as the output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win       <= '0;
            r_out_valid <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (w_accept) begin
            r_win       <= w_win;
            r_col       <= w_col_last ? '0 : w_col + COL_W'(1);
            if (w_col_last) begin
                r_row <= w_row_last ? '0 : w_row + ROW_W'(1);
            end else begin
                r_row <= w_row;
            end
            // Only interior-complete positions produce a visible window.
            r_out_valid <= (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
            r_out_eof   <= w_row_last && w_col_last;
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_out_eof   <= 1'b0;
        end
    end

    assign OUT_WIN   = r_win;
    assign OUT_VALID = r_out_valid;
    assign OUT_EOF   = r_out_eof;

endmodule

// File: tb/tb_sharp_window_gen.sv
// tb_sharp_window_gen: directed and randomised-handshake checks of the
// 3x3 window generator on a 4x4 image, pixel (r,c) = base + 0x10*r + c.
module tb_sharp_window_gen;

    localparam int unsigned DW  = 16;
    localparam int unsigned W   = 4;
    localparam int unsigned H   = 4;
    localparam int unsigned WWN = 9 * DW;

    logic           CLK = 1'b0;
    logic           RST;
    logic [DW-1:0]  IN_DATA;
    logic           IN_VALID;
    logic           IN_SOF;
    logic           IN_READY;
    logic [WWN-1:0] OUT_WIN;
    logic           OUT_VALID;
    logic           OUT_EOF;
    logic           OUT_READY;

    sharp_window_gen #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_SOF    (IN_SOF),
        .IN_READY  (IN_READY),
        .OUT_WIN   (OUT_WIN),
        .OUT_VALID (OUT_VALID),
        .OUT_EOF   (OUT_EOF),
        .OUT_READY (OUT_READY)
    );

    always #5 CLK = ~CLK;

    int nerr = 0;
    int nchk = 0;

    int             px_q[$];
    bit             sof_q[$];
    logic [WWN-1:0] cap_win[$];
    logic           cap_eof[$];
    int             acc_cyc[$];
    int             first_valid_cyc;

    // Reference window for the pixel accepted at (r,c) of a frame with offset base.
    function automatic logic [WWN-1:0] exp_win(input int base, input int r, input int c);
        logic [WWN-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v[DW*(3*i+j) +: DW] = DW'(base + 16*(r-2+i) + (c-2+j));
            end
        end
        return v;
    endfunction

    task automatic add_frame(input int base, input bit sof);
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                px_q.push_back(base + 16*r + c);
                sof_q.push_back(sof && r == 0 && c == 0);
            end
        end
    endtask

    // Streams px_q[start..] with random valid/ready and records consumed windows.
    task automatic drive(input int start, input int vprob, input int rprob, output bit to);
        int idx;
        int cyc;
        int drain;
        idx   = start;
        cyc   = 0;
        drain = 0;
        cap_win.delete();
        cap_eof.delete();
        acc_cyc.delete();
        first_valid_cyc = -1;
        while (cyc < 5000 && drain < 4) begin
            @(negedge CLK);
            if (idx < px_q.size()) begin
                IN_VALID  = ($urandom_range(99) < vprob);
                IN_DATA   = DW'(px_q[idx]);
                IN_SOF    = sof_q[idx];
                OUT_READY = ($urandom_range(99) < rprob);
            end else begin
                IN_VALID  = 1'b0;
                IN_SOF    = 1'b0;
                OUT_READY = 1'b1;
                drain++;
            end
            #1;
            if (OUT_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (OUT_VALID && OUT_READY) begin
                cap_win.push_back(OUT_WIN);
                cap_eof.push_back(OUT_EOF);
            end
            if (IN_VALID && IN_READY) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN_SOF   = 1'b0;
        to = (idx < px_q.size()) || (drain < 4);
    endtask

    task automatic test_reset;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        IN_SOF    = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        nchk++;
        if (OUT_VALID !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", OUT_VALID); end
        nchk++;
        if (OUT_EOF !== 1'b0) begin nerr++; $display("FAIL reset_eof: got %b expected 0", OUT_EOF); end
        nchk++;
        if (OUT_WIN !== '0) begin nerr++; $display("FAIL reset_win: got %h expected 0", OUT_WIN); end
        nchk++;
        if (IN_READY !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic;
        bit to;
        px_q.delete();
        sof_q.delete();
        add_frame(0, 1'b1);
        drive(0, 100, 100, to);
        nchk++;
        if (to !== 1'b0) begin nerr++; $display("FAIL basic_timeout: got %b expected 0", to); end
        nchk++;
        if (cap_win.size() != 4) begin nerr++; $display("FAIL basic_count: got %0d expected 4", cap_win.size()); end
        nchk++;
        if (acc_cyc.size() < 11 || first_valid_cyc != acc_cyc[10] + 1) begin
            nerr++;
            $display("FAIL basic_latency: got cycle %0d expected one after accept of 0x22", first_valid_cyc);
        end
        if (cap_win.size() == 4) begin
            nchk++;
            if (cap_win[0][0 +: DW] !== 16'h0000 || cap_win[0][4*DW +: DW] !== 16'h0011 ||
                cap_win[0][8*DW +: DW] !== 16'h0022) begin
                nerr++;
                $display("FAIL basic_first_k048: got %h expected k0=0000 k4=0011 k8=0022", cap_win[0]);
            end
            nchk++;
            if (cap_win[3][8*DW +: DW] !== 16'h0033 || cap_eof[3] !== 1'b1) begin
                nerr++;
                $display("FAIL basic_last: got k8=%h eof=%b expected 0033 1", cap_win[3][8*DW +: DW], cap_eof[3]);
            end
            for (int n = 0; n < 4; n++) begin
                nchk++;
                if (cap_win[n] !== exp_win(0, 2 + n/2, 2 + n%2) || cap_eof[n] !== (n == 3)) begin
                    nerr++;
                    $display("FAIL basic_win%0d: got %h eof=%b expected %h", n, cap_win[n], cap_eof[n],
                             exp_win(0, 2 + n/2, 2 + n%2));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int             idx;
        bit             got;
        bit             to;
        logic [WWN-1:0] held;
        px_q.delete();
        sof_q.delete();
        add_frame(0, 1'b1);
        idx = 0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                got = 1'b1;
            end else begin
                IN_VALID  = 1'b1;
                IN_DATA   = DW'(px_q[idx]);
                IN_SOF    = sof_q[idx];
                OUT_READY = 1'b1;
                #1;
                if (IN_READY) idx++;
            end
        end
        nchk++;
        if (got !== 1'b1) begin nerr++; $display("FAIL bp_first_window: got %b expected 1", got); end
        held = OUT_WIN;
        for (int h = 0; h < 5; h++) begin
            if (h > 0) @(negedge CLK);
            IN_VALID  = 1'b1;
            IN_DATA   = DW'(px_q[idx]);
            IN_SOF    = sof_q[idx];
            OUT_READY = 1'b0;
            #1;
            nchk++;
            if (IN_READY !== 1'b0) begin nerr++; $display("FAIL bp_in_ready%0d: got %b expected 0", h, IN_READY); end
            nchk++;
            if (OUT_VALID !== 1'b1 || OUT_WIN !== held) begin
                nerr++;
                $display("FAIL bp_hold%0d: got valid=%b win=%h expected 1 %h", h, OUT_VALID, OUT_WIN, held);
            end
        end
        drive(idx, 100, 100, to);
        nchk++;
        if (to !== 1'b0 || cap_win.size() != 4) begin
            nerr++;
            $display("FAIL bp_count: got %0d timeout=%b expected 4", cap_win.size(), to);
        end
        for (int n = 0; n < 4 && n < cap_win.size(); n++) begin
            nchk++;
            if (cap_win[n] !== exp_win(0, 2 + n/2, 2 + n%2) || cap_eof[n] !== (n == 3)) begin
                nerr++;
                $display("FAIL bp_win%0d: got %h eof=%b expected %h", n, cap_win[n], cap_eof[n],
                         exp_win(0, 2 + n/2, 2 + n%2));
            end
        end
    endtask

    task automatic test_back_to_back;
        bit to;
        int base;
        px_q.delete();
        sof_q.delete();
        add_frame(0, 1'b1);
        add_frame(32'h80, 1'b0);
        drive(0, 100, 100, to);
        nchk++;
        if (to !== 1'b0 || cap_win.size() != 8) begin
            nerr++;
            $display("FAIL b2b_count: got %0d timeout=%b expected 8", cap_win.size(), to);
        end
        for (int n = 0; n < 8 && n < cap_win.size(); n++) begin
            base = (n < 4) ? 0 : 32'h80;
            nchk++;
            if (cap_win[n] !== exp_win(base, 2 + (n%4)/2, 2 + n%2) || cap_eof[n] !== (n%4 == 3)) begin
                nerr++;
                $display("FAIL b2b_win%0d: got %h eof=%b expected %h", n, cap_win[n], cap_eof[n],
                         exp_win(base, 2 + (n%4)/2, 2 + n%2));
            end
        end
    endtask

    task automatic test_sof_mid;
        bit to;
        px_q.delete();
        sof_q.delete();
        // Abandoned frame runs up to (2,0); the new frame's origin pixel is 0x21.
        for (int p = 0; p < 9; p++) begin
            px_q.push_back(16*(p/4) + p%4);
            sof_q.push_back(p == 0);
        end
        add_frame(32'h21, 1'b1);
        drive(0, 100, 100, to);
        nchk++;
        if (to !== 1'b0 || cap_win.size() != 4) begin
            nerr++;
            $display("FAIL sof_count: got %0d timeout=%b expected 4", cap_win.size(), to);
        end
        for (int n = 0; n < 4 && n < cap_win.size(); n++) begin
            nchk++;
            if (cap_win[n] !== exp_win(32'h21, 2 + n/2, 2 + n%2) || cap_eof[n] !== (n == 3)) begin
                nerr++;
                $display("FAIL sof_win%0d: got %h eof=%b expected %h", n, cap_win[n], cap_eof[n],
                         exp_win(32'h21, 2 + n/2, 2 + n%2));
            end
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        px_q.delete();
        sof_q.delete();
        for (int p = 0; p < 8; p++) begin
            px_q.push_back(16*(p/4) + p%4);
            sof_q.push_back(p == 0);
        end
        drive(0, 100, 100, to);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        nchk++;
        if (OUT_VALID !== 1'b0 || OUT_EOF !== 1'b0 || OUT_WIN !== '0) begin
            nerr++;
            $display("FAIL rstmid_outputs: got valid=%b eof=%b win=%h expected 0 0 0", OUT_VALID, OUT_EOF, OUT_WIN);
        end
        @(negedge CLK);
        RST = 1'b0;
        px_q.delete();
        sof_q.delete();
        add_frame(0, 1'b0);
        drive(0, 100, 100, to);
        nchk++;
        if (to !== 1'b0 || cap_win.size() != 4) begin
            nerr++;
            $display("FAIL rstmid_count: got %0d timeout=%b expected 4", cap_win.size(), to);
        end
        for (int n = 0; n < 4 && n < cap_win.size(); n++) begin
            nchk++;
            if (cap_win[n] !== exp_win(0, 2 + n/2, 2 + n%2) || cap_eof[n] !== (n == 3)) begin
                nerr++;
                $display("FAIL rstmid_win%0d: got %h eof=%b expected %h", n, cap_win[n], cap_eof[n],
                         exp_win(0, 2 + n/2, 2 + n%2));
            end
        end
    endtask

    task automatic test_random;
        bit to;
        int f;
        px_q.delete();
        sof_q.delete();
        for (int k = 0; k < 20; k++) add_frame(k * 32'h100, 1'b1);
        drive(0, 60, 60, to);
        nchk++;
        if (to !== 1'b0 || cap_win.size() != 80) begin
            nerr++;
            $display("FAIL rand_count: got %0d timeout=%b expected 80", cap_win.size(), to);
        end
        for (int n = 0; n < 80 && n < cap_win.size(); n++) begin
            f = n / 4;
            nchk++;
            if (cap_win[n] !== exp_win(f * 32'h100, 2 + (n%4)/2, 2 + n%2) || cap_eof[n] !== (n%4 == 3)) begin
                nerr++;
                $display("FAIL rand_win%0d: got %h eof=%b expected %h", n, cap_win[n], cap_eof[n],
                         exp_win(f * 32'h100, 2 + (n%4)/2, 2 + n%2));
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_sof_mid;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
